dcache_ctrl: RTL

//  Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.

---
 rtl/dcache_ctrl_if.sv | 25 ++
 rtl/dcache_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU-side and backing-memory-side signal bundle for the L1 data cache.
interface dcache_ctrl_if;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache; hits complete in zero cycles,
// misses stall the pipeline through an optional victim write-back and a line fetch.
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 5 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [255:0]         data_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       wsel;
    logic             hit;
    logic [255:0]     line;
    logic             fill;
    logic             store_hit;
    logic             stall;
    logic [31:0]      rd_data;
    logic             mreq;
    logic             mwe;
    logic [31:0]      maddr;
    logic [255:0]     mdata;
    logic             unused_addr;

    assign idx         = bus.cpu_addr_i[5 +: IDX_W];
    assign req_tag     = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel        = bus.cpu_addr_i[4:2];
    assign line        = data_q[idx];
    assign hit         = bus.cpu_req_i & valid_q[idx] & (tag_q[idx] == req_tag);
    assign unused_addr = ^bus.cpu_addr_i[1:0];

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        fill      = 1'b0;
        store_hit = 1'b0;
        stall     = 1'b0;
        rd_data   = '0;
        mreq      = 1'b0;
        mwe       = 1'b0;
        maddr     = '0;
        mdata     = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req_i) begin
                    if (hit) begin
                        if (bus.cpu_we_i) begin
                            store_hit     = 1'b1;
                            dirty_d[idx]  = 1'b1;
                        end else begin
                            rd_data = line[{wsel, 5'b0} +: 32];
                        end
                    end else begin
                        stall   = 1'b1;
                        state_d = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                // Index comes from the held request, so the victim stays selected until ack.
                stall = 1'b1;
                mreq  = 1'b1;
                mwe   = 1'b1;
                maddr = {tag_q[idx], idx, 5'b0};
                mdata = line;
                if (bus.mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                stall = 1'b1;
                mreq  = 1'b1;
                maddr = {req_tag, idx, 5'b0};
                if (bus.mem_ack_i) begin
                    fill         = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag/data arrays carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i && fill) begin
            data_q[idx] <= bus.mem_data_i;
            tag_q[idx]  <= req_tag;
        end else if (!rst_i && store_hit) begin
            data_q[idx][{wsel, 5'b0} +: 32] <= bus.cpu_data_i;
        end
    end

    assign bus.cpu_stall_o = stall;
    assign bus.cpu_data_o  = rd_data;
    assign bus.mem_req_o   = mreq;
    assign bus.mem_we_o    = mwe;
    assign bus.mem_addr_o  = maddr;
    assign bus.mem_data_o  = mdata;
endmodule
